// File: rtl/vga_pkg.sv
// Shared timing definitions for the VGA sync generator.
//   eixo_t          : active/front-porch/sync/back-porch widths and sync polarity of one axis
//   temporizacao_t  : horizontal + vertical axis pair
//   VGA_640X480_60  : 640x480@60 timing set (sync active-low)
//   VGA_800X600_60  : 800x600@60 timing set (sync active-high)
//   f_clog2         : width needed to hold the values 0..v-1
package vga_pkg;

  typedef struct packed {
    int unsigned ativo;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    logic        pol;
  } eixo_t;

  typedef struct packed {
    eixo_t h;
    eixo_t v;
  } temporizacao_t;

  localparam temporizacao_t VGA_640X480_60 = '{
    h: '{ativo: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0},
    v: '{ativo: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0}
  };

  localparam temporizacao_t VGA_800X600_60 = '{
    h: '{ativo: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1},
    v: '{ativo: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1}
  };

  function automatic int unsigned f_clog2(input int unsigned v);
    for (int unsigned r = 0; r < 32; r++) begin
      if ((64'd1 << r) >= 64'(v)) return r;
    end
    return 32;
  endfunction

endpackage

// File: rtl/vga_sinc_param_if.sv
// Video timing bus produced by vga_sinc_param.
//   master : driven by the sync generator
//   slave  : consumed by the pixel/colour generator
// Signals: h_sync, v_sync, coluna[CWH], linha[CWV], regiaoAtiva,
//          inicioLinha, inicioQuadro, inicioVblank, quadro[QW]
interface vga_sinc_param_if #(
  parameter int unsigned CWH = 10,
  parameter int unsigned CWV = 10,
  parameter int unsigned QW  = 8
);
  logic           h_sync;
  logic           v_sync;
  logic [CWH-1:0] coluna;
  logic [CWV-1:0] linha;
  logic           regiaoAtiva;
  logic           inicioLinha;
  logic           inicioQuadro;
  logic           inicioVblank;
  logic [QW-1:0]  quadro;

  modport master (
    output h_sync, v_sync, coluna, linha, regiaoAtiva,
           inicioLinha, inicioQuadro, inicioVblank, quadro
  );

  modport slave (
    input  h_sync, v_sync, coluna, linha, regiaoAtiva,
           inicioLinha, inicioQuadro, inicioVblank, quadro
  );
endinterface

// File: rtl/vga_contador_eixo.sv
// One timing axis (horizontal or vertical) of the VGA sync generator.
// Ports:
//   clk, reset (sync, active-low), inc (advance this axis by one)
//   cont  : registered position 0..T-1
//   wrap  : combinational, high when this inc takes cont from T-1 back to 0
//   sync  : registered sync level for cont
//   ativo : registered, high while cont < ATIVO
// sync/ativo are decoded from the next count so they line up with cont.
module vga_contador_eixo
  import vga_pkg::*;
#(
  parameter int unsigned ATIVO = 640,
  parameter int unsigned FP    = 16,
  parameter int unsigned SYNC  = 96,
  parameter int unsigned BP    = 48,
  parameter bit          POL   = 1'b0,
  localparam int unsigned T    = ATIVO + FP + SYNC + BP,
  localparam int unsigned CW   = f_clog2(T)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  output logic [CW-1:0] cont,
  output logic          wrap,
  output logic          sync,
  output logic          ativo
);

  localparam int unsigned S_INI = ATIVO + FP;
  localparam int unsigned S_FIM = ATIVO + FP + SYNC - 1;

  if (ATIVO < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_param_invalido
    $error("vga_contador_eixo: active, porch and sync widths must all be >= 1");
  end

  logic [CW-1:0] w_prox;

  always_comb begin
    wrap   = inc && (cont == CW'(T - 1));
    w_prox = cont;
    if (wrap)     w_prox = '0;
    else if (inc) w_prox = cont + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cont  <= '0;
      sync  <= ~POL;
      ativo <= 1'b1;
    end else begin
      cont  <= w_prox;
      sync  <= (w_prox >= CW'(S_INI) && w_prox <= CW'(S_FIM)) ? POL : ~POL;
      ativo <= (w_prox < CW'(ATIVO));
    end
  end

endmodule

// File: rtl/vga_sinc_param.sv
// Parametrised VGA sync generator with pixel clock-enable.
// Ports:
//   clk   : system clock
//   reset : synchronous reset, active-low (overrides ce)
//   ce    : pixel enable, counters advance only on edges with ce=1
//   bus   : vga_sinc_param_if master -- syncs, coluna/linha, regiaoAtiva,
//           inicioLinha/inicioQuadro/inicioVblank pulses, quadro counter
// All outputs come from flops decoded from the next (linha,coluna), so
// coordinates, syncs and pulses carry no relative skew.
module vga_sinc_param
  import vga_pkg::*;
#(
  parameter int unsigned H_ATIVO = VGA_640X480_60.h.ativo,
  parameter int unsigned H_FP    = VGA_640X480_60.h.fp,
  parameter int unsigned H_SYNC  = VGA_640X480_60.h.sync,
  parameter int unsigned H_BP    = VGA_640X480_60.h.bp,
  parameter int unsigned V_ATIVO = VGA_640X480_60.v.ativo,
  parameter int unsigned V_FP    = VGA_640X480_60.v.fp,
  parameter int unsigned V_SYNC  = VGA_640X480_60.v.sync,
  parameter int unsigned V_BP    = VGA_640X480_60.v.bp,
  parameter bit          H_POL   = VGA_640X480_60.h.pol,
  parameter bit          V_POL   = VGA_640X480_60.v.pol,
  parameter int unsigned QW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  vga_sinc_param_if.master  bus
);

  localparam int unsigned HT  = H_ATIVO + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT  = V_ATIVO + V_FP + V_SYNC + V_BP;
  localparam int unsigned CWH = f_clog2(HT);
  localparam int unsigned CWV = f_clog2(VT);

  if (QW < 1) begin : g_qw_invalido
    $error("vga_sinc_param: QW must be >= 1");
  end

  logic [CWH-1:0] w_coluna;
  logic [CWV-1:0] w_linha;
  logic           w_wrap_h, w_wrap_v, w_inc_v;
  logic           w_sync_h, w_sync_v;
  logic           w_ativo_h, w_ativo_v;
  logic           r_inicioLinha, r_inicioQuadro, r_inicioVblank;
  logic [QW-1:0]  r_quadro;

  assign w_inc_v = ce & w_wrap_h;

  vga_contador_eixo #(
    .ATIVO (H_ATIVO),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (H_POL)
  ) u_eixo_h (
    .clk   (clk),
    .reset (reset),
    .inc   (ce),
    .cont  (w_coluna),
    .wrap  (w_wrap_h),
    .sync  (w_sync_h),
    .ativo (w_ativo_h)
  );

  vga_contador_eixo #(
    .ATIVO (V_ATIVO),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (V_POL)
  ) u_eixo_v (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_v),
    .cont  (w_linha),
    .wrap  (w_wrap_v),
    .sync  (w_sync_v),
    .ativo (w_ativo_v)
  );

  // Pulses are rebuilt every edge from this edge's advance only, so they
  // fall back to 0 on the next clk regardless of ce.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_inicioLinha  <= 1'b0;
      r_inicioQuadro <= 1'b0;
      r_inicioVblank <= 1'b0;
      r_quadro       <= '0;
    end else begin
      r_inicioLinha  <= w_wrap_h;
      r_inicioQuadro <= w_wrap_v;
      r_inicioVblank <= w_inc_v && (w_linha == CWV'(V_ATIVO - 1));
      if (w_wrap_v) r_quadro <= r_quadro + 1'b1;
    end
  end

  assign bus.h_sync       = w_sync_h;
  assign bus.v_sync       = w_sync_v;
  assign bus.coluna       = w_coluna;
  assign bus.linha        = w_linha;
  assign bus.regiaoAtiva  = w_ativo_h & w_ativo_v;
  assign bus.inicioLinha  = r_inicioLinha;
  assign bus.inicioQuadro = r_inicioQuadro;
  assign bus.inicioVblank = r_inicioVblank;
  assign bus.quadro       = r_quadro;

endmodule

// File: tb/tb_vga_sinc_param.sv
// Bench for vga_sinc_param: two reduced-size instances (active-low and
// active-high sync) share clk/reset/ce. The reference tracks only the number
// of pixel advances since reset and derives every output arithmetically.
module tb_vga_sinc_param;

  // Instance A: H 8/2/3/2 (HT=15), V 5/1/2/2 (VT=10), active-low, QW=3
  localparam int unsigned A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int unsigned A_VA = 5, A_VF = 1, A_VS = 2, A_VB = 2;
  localparam int unsigned A_QW = 3;
  // Instance B: H 6/1/2/3 (HT=12), V 4/1/1/1 (VT=7), active-high, QW=2
  localparam int unsigned B_HA = 6, B_HF = 1, B_HS = 2, B_HB = 3;
  localparam int unsigned B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int unsigned B_QW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ce = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  longint unsigned n_adv = 0;
  bit              adv = 1'b0;

  always #5 clk = ~clk;

  vga_sinc_param_if #(.CWH(4), .CWV(4), .QW(A_QW)) bus_a ();
  vga_sinc_param_if #(.CWH(4), .CWV(3), .QW(B_QW)) bus_b ();

  vga_sinc_param #(
    .H_ATIVO(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ATIVO(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .H_POL(1'b0), .V_POL(1'b0), .QW(A_QW)
  ) dut_a (.clk(clk), .reset(reset), .ce(ce), .bus(bus_a));

  vga_sinc_param #(
    .H_ATIVO(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ATIVO(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(1'b1), .V_POL(1'b1), .QW(B_QW)
  ) dut_b (.clk(clk), .reset(reset), .ce(ce), .bus(bus_b));

  typedef struct {
    logic [31:0] col, lin, q;
    logic        hs, vs, ra, il, iq, iv;
  } exp_t;

  function automatic exp_t modelo(input longint unsigned n, input bit a,
      input int unsigned ha, hf, hw, hb, va, vf, vw, vb,
      input bit hp, vp, input int unsigned qw);
    exp_t e;
    longint unsigned ht, vt, c, l;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    c  = n % ht;
    l  = (n / ht) % vt;
    e.col = 32'(c);
    e.lin = 32'(l);
    e.q   = 32'((n / (ht * vt)) % (64'd1 << qw));
    e.hs  = (c >= ha + hf && c <= ha + hf + hw - 1) ? hp : ~hp;
    e.vs  = (l >= va + vf && l <= va + vf + vw - 1) ? vp : ~vp;
    e.ra  = (c < ha) && (l < va);
    e.il  = a && (c == 0);
    e.iq  = a && (c == 0) && (l == 0);
    e.iv  = a && (c == 0) && (l == va);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s n=%0d observed=%0d expected=%0d", tag, n_adv, obs, exp);
    end
  endtask

  task automatic verifica();
    exp_t ea, eb;
    ea = modelo(n_adv, adv, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 1'b0, A_QW);
    eb = modelo(n_adv, adv, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 1'b1, B_QW);
    chk("A.coluna",       32'(bus_a.coluna),       ea.col);
    chk("A.linha",        32'(bus_a.linha),        ea.lin);
    chk("A.quadro",       32'(bus_a.quadro),       ea.q);
    chk("A.h_sync",       32'(bus_a.h_sync),       32'(ea.hs));
    chk("A.v_sync",       32'(bus_a.v_sync),       32'(ea.vs));
    chk("A.regiaoAtiva",  32'(bus_a.regiaoAtiva),  32'(ea.ra));
    chk("A.inicioLinha",  32'(bus_a.inicioLinha),  32'(ea.il));
    chk("A.inicioQuadro", 32'(bus_a.inicioQuadro), 32'(ea.iq));
    chk("A.inicioVblank", 32'(bus_a.inicioVblank), 32'(ea.iv));
    chk("B.coluna",       32'(bus_b.coluna),       eb.col);
    chk("B.linha",        32'(bus_b.linha),        eb.lin);
    chk("B.quadro",       32'(bus_b.quadro),       eb.q);
    chk("B.h_sync",       32'(bus_b.h_sync),       32'(eb.hs));
    chk("B.v_sync",       32'(bus_b.v_sync),       32'(eb.vs));
    chk("B.regiaoAtiva",  32'(bus_b.regiaoAtiva),  32'(eb.ra));
    chk("B.inicioLinha",  32'(bus_b.inicioLinha),  32'(eb.il));
    chk("B.inicioQuadro", 32'(bus_b.inicioQuadro), 32'(eb.iq));
    chk("B.inicioVblank", 32'(bus_b.inicioVblank), 32'(eb.iv));
  endtask

  // Drive one edge's inputs, let the edge happen, update the reference, compare.
  task automatic passo(input logic rst_n, input logic ce_v);
    reset = rst_n;
    ce    = ce_v;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      n_adv = 0;
      adv   = 1'b0;
    end else if (ce_v) begin
      n_adv = n_adv + 1;
      adv   = 1'b1;
    end else begin
      adv   = 1'b0;
    end
    verifica();
  endtask

  initial begin
    // Reset with ce high, then with ce low
    @(negedge clk);
    passo(1'b0, 1'b1);
    passo(1'b0, 1'b1);
    passo(1'b0, 1'b0);

    // Free-running: several frames of both instances, quadro wraps in A and B
    for (int i = 0; i < 1300; i++) passo(1'b1, 1'b1);

    // ce toggled 1-0-1-0: outputs hold on ce=0, pulses one clk wide
    for (int i = 0; i < 400; i++) passo(1'b1, (i % 2) == 0);

    // Sparse random ce
    for (int i = 0; i < 1500; i++) passo(1'b1, $urandom_range(0, 3) == 0);

    // Reset mid-frame with ce=1, run on, then reset mid-frame with ce=0
    for (int i = 0; i < 77; i++) passo(1'b1, 1'b1);
    passo(1'b0, 1'b1);
    for (int i = 0; i < 53; i++) passo(1'b1, 1'b1);
    passo(1'b0, 1'b0);
    passo(1'b1, 1'b0);

    // Random ce with occasional random resets
    for (int i = 0; i < 2000; i++)
      passo($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sinc_param.md
Name: vga_sinc_param

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Generates h_sync/v_sync, pixel coordinates and active-region flag for any resolution and timing set, with configurable sync polarity.
- Adds a pixel clock-enable so the block runs from a faster system clock, plus line/frame/vblank event pulses and a frame counter for framebuffer swap logic.
- Sits between the clock/PLL and the pixel/colour generator.

Parameters:
- H_ATIVO, 640, active columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ATIVO, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, h_sync asserted level (0 = active-low)
- V_POL, 0, v_sync asserted level (0 = active-low)
- QW, 8, frame counter width

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous reset, active-low
- ce, input, 1, pixel enable; counters advance only on clk edges with ce=1
- h_sync, output, 1, horizontal sync (registered)
- v_sync, output, 1, vertical sync (registered)
- coluna, output, CWH, current column; CWH = clog2(H_ATIVO+H_FP+H_SYNC+H_BP)
- linha, output, CWV, current line; CWV = clog2(V_ATIVO+V_FP+V_SYNC+V_BP)
- regiaoAtiva, output, 1, high when coluna<H_ATIVO and linha<V_ATIVO
- inicioLinha, output, 1, one-clk pulse when coluna becomes 0
- inicioQuadro, output, 1, one-clk pulse when (linha,coluna) becomes (0,0)
- inicioVblank, output, 1, one-clk pulse when (linha,coluna) becomes (V_ATIVO,0)
- quadro, output, QW, frame counter

Behaviour:
- Totals: HT = H_ATIVO+H_FP+H_SYNC+H_BP (default 800); VT = V_ATIVO+V_FP+V_SYNC+V_BP (default 525).
- All outputs are registered. Every flag is a function of the same (linha,coluna) presented in that cycle: zero skew between coordinates and syncs. Implementation decodes next-state values.
- Reset (reset=0 on a clk edge, overrides ce):
  - coluna=0, linha=0, quadro=0.
  - regiaoAtiva=1.
  - h_sync=~H_POL, v_sync=~V_POL (inactive).
  - All pulses 0.
- Advance (reset=1, ce=1):
  - coluna = (coluna==HT-1) ? 0 : coluna+1.
  - On horizontal wrap: linha = (linha==VT-1) ? 0 : linha+1.
  - On full-frame wrap: quadro increments, wrapping modulo 2^QW.
- ce=0: coordinates, syncs, regiaoAtiva and quadro hold. All pulses are 0 in any cycle not caused by an advance, so each pulse lasts exactly one clk even when ce is sparse.
- h_sync = H_POL iff H_ATIVO+H_FP <= coluna <= H_ATIVO+H_FP+H_SYNC-1 (default 656..751); else ~H_POL.
- v_sync = V_POL iff V_ATIVO+V_FP <= linha <= V_ATIVO+V_FP+V_SYNC-1 (default 490..491). v_sync changes on the same edge as the line change, i.e. at coluna=0.
- inicioLinha fires on every horizontal wrap, including the wrap into (0,0). inicioQuadro and inicioVblank coincide with an inicioLinha.
- The reset release cycle at (0,0) does not raise inicioQuadro; the first pulse occurs at the first wrap.
- Reset mid-frame: next edge returns to (0,0) with no pulses; quadro is cleared.
- Legal parameters: every porch and sync width >=1; any violation is flagged by an elaboration-time check.

Decomposition:
- Package vga_pkg holds:
  - timing constant sets for 640x480@60 and 800x600@60 (active/FP/sync/BP per axis, polarities);
  - a clog2 width helper.
- One sub-module, vga_contador_eixo, instantiated twice (horizontal and vertical):
  - params ATIVO, FP, SYNC, BP, POL;
  - inputs clk, reset, inc;
  - outputs cont, wrap, sync, ativo, all computed from the next value.
- The top level chains inc_v = ce & wrap_h, then ANDs the two ativo outputs and builds the pulses and quadro.

Test Plan:
- Reset with ce=1 tied, 2 full frames -> h_sync low exactly for coluna 656..751, 96 clks per line; v_sync low for linha 490..491, 1600 clks; line period 800 clks, frame period 420000 clks.
- ce toggled 1-0-1-0 -> coordinates advance every 2 clks, frame period 840000 clks; each inicioLinha pulse is 1 clk wide; all outputs hold when ce=0.
- Boundary check -> at (479,639) regiaoAtiva=1; next advance to (479,640) gives regiaoAtiva=0; advance from (479,799) gives (480,0) with inicioVblank=1 and inicioLinha=1.
- Wrap (524,799) -> (0,0) -> inicioQuadro=1 for 1 clk; quadro increments; quadro=255 wraps to 0 with QW=8.
- reset=0 asserted at (300,400) for 1 clk -> next cycle (0,0), quadro=0, syncs inactive, no pulses; reset=0 with ce=0 behaves identically.
- 800x600 set with H_POL=1, V_POL=1 (H 800/40/128/88, V 600/1/4/23) -> h_sync high for coluna 840..967, v_sync high for linha 601..604, HT=1056, VT=628.
